// File: rtl/gray_seq_ctrl.sv
// Gray-code step sequencer: runs a modulo-MOD counter for a requested number of advances.
// Latency: one advance per cycle after start; outputs registered. Backpressure: pause level holds, stop aborts.
// Optional GRAY_SEQ_DOWN_EN adds a dir input for down-counting.
module gray_seq_ctrl #(
    parameter  int MOD     = 16,
    parameter  int STEPS_W = 8,
    localparam int CW      = $clog2(MOD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STEPS_W-1:0] steps,
    input  logic               pause,
    input  logic               stop,
    input  logic               clr,
`ifdef GRAY_SEQ_DOWN_EN
    input  logic               dir,
`endif
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic [STEPS_W-1:0] remaining,
    output logic [CW-1:0]      bin_out,
    output logic [CW-1:0]      gray_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [CW-1:0] MAXV = CW'(MOD - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;
    logic [STEPS_W-1:0] r_rem;
    logic [CW-1:0]      r_bin;
    logic [CW-1:0]      r_gray;

    logic               w_adv;
    logic               w_load;
    logic               w_clr_cnt;
    logic               w_abort;
    logic [CW-1:0]      w_bin_nxt;
    logic [CW-1:0]      w_gray_nxt;
    logic               w_wrap_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && (steps != '0)) w_next = S_RUN;
            S_RUN: begin
                if (stop)                             w_next = S_IDLE;
                else if (pause)                       w_next = S_HOLD;
                else if (r_rem == STEPS_W'(1))        w_next = S_DONE;
            end
            S_HOLD: begin
                if (stop)        w_next = S_IDLE;
                else if (!pause) w_next = S_RUN;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_adv     = (r_state == S_RUN) && !stop && !pause;
        w_load    = (r_state == S_IDLE) && start && (steps != '0);
        w_clr_cnt = (r_state == S_IDLE) && clr;
        w_abort   = ((r_state == S_RUN) || (r_state == S_HOLD)) && stop;
    end

    // Wrap compares against MOD-1 (or 0 going down) so non-power-of-two moduli never reach 2^CW.
    always_comb begin
        w_bin_nxt  = (r_bin == MAXV) ? '0 : r_bin + CW'(1);
        w_wrap_nxt = (r_bin == MAXV);
`ifdef GRAY_SEQ_DOWN_EN
        if (dir) begin
            w_bin_nxt  = (r_bin == '0) ? MAXV : r_bin - CW'(1);
            w_wrap_nxt = (r_bin == '0);
        end
`endif
        w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            r_rem  <= '0;
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_busy <= (w_next == S_RUN) || (w_next == S_HOLD);
            r_done <= (w_next == S_DONE);
            r_wrap <= w_adv && w_wrap_nxt;
            if (w_clr_cnt) begin
                r_bin  <= '0;
                r_gray <= '0;
            end else if (w_adv) begin
                r_bin  <= w_bin_nxt;
                r_gray <= w_gray_nxt;
            end
            if (w_load)       r_rem <= steps;
            else if (w_abort) r_rem <= '0;
            else if (w_adv)   r_rem <= r_rem - STEPS_W'(1);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign remaining = r_rem;
    assign bin_out   = r_bin;
    assign gray_out  = r_gray;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl (MOD=10): directed scenarios plus random stimulus against a reference model,
// with expected outputs queued per cycle and checked by an independent monitor.
module tb_gray_seq_ctrl;

    localparam int MOD = 10;
    localparam int SW  = 8;
    localparam int CW  = $clog2(MOD);

    logic          clk = 1'b0;
    logic          rst, start, pause, stop, clr, dir;
    logic [SW-1:0] steps;
    logic          busy, done, wrap;
    logic [SW-1:0] remaining;
    logic [CW-1:0] bin_out, gray_out;

    typedef struct {
        logic          busy;
        logic          done;
        logic          wrap;
        logic [SW-1:0] rem;
        logic [CW-1:0] bin;
        logic [CW-1:0] gray;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: phase 0 idle, 1 running, 2 held, 3 finishing
    int m_phase = 0, m_bin = 0, m_rem = 0;

    gray_seq_ctrl #(.MOD(MOD), .STEPS_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .steps(steps), .pause(pause),
        .stop(stop), .clr(clr),
`ifdef GRAY_SEQ_DOWN_EN
        .dir(dir),
`endif
        .busy(busy), .done(done), .wrap(wrap), .remaining(remaining),
        .bin_out(bin_out), .gray_out(gray_out)
    );

    always #5 clk = ~clk;

    task automatic cyc(input bit r, input bit s, input int n, input bit p,
                       input bit sp, input bit c, input bit d);
        exp_t e;
        bit   m_done, m_wrap, down;
        @(negedge clk);
        rst = r; start = s; steps = SW'(n); pause = p; stop = sp; clr = c; dir = d;
`ifdef GRAY_SEQ_DOWN_EN
        down = d;
`else
        down = 1'b0;
`endif
        m_done = 0;
        m_wrap = 0;
        if (r) begin
            m_phase = 0; m_bin = 0; m_rem = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (c) m_bin = 0;
                    if (s && n != 0) begin m_phase = 1; m_rem = n; end
                end
                1: begin
                    if (sp) begin m_phase = 0; m_rem = 0; end
                    else if (p) m_phase = 2;
                    else begin
                        m_bin = down ? (m_bin + MOD - 1) % MOD : (m_bin + 1) % MOD;
                        m_wrap = down ? (m_bin == MOD - 1) : (m_bin == 0);
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin m_phase = 3; m_done = 1; end
                    end
                end
                2: begin
                    if (sp) begin m_phase = 0; m_rem = 0; end
                    else if (!p) m_phase = 1;
                end
                default: m_phase = 0;
            endcase
        end
        e.busy = (m_phase == 1) || (m_phase == 2);
        e.done = m_done;
        e.wrap = m_wrap;
        e.rem  = SW'(m_rem);
        e.bin  = CW'(m_bin);
        e.gray = CW'(m_bin ^ (m_bin >> 1));
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (busy !== e.busy || done !== e.done || wrap !== e.wrap ||
                remaining !== e.rem || bin_out !== e.bin || gray_out !== e.gray) begin
                miscompares++;
                $display("FAIL outputs t=%0t got busy=%b done=%b wrap=%b rem=%0d bin=%0d gray=%0d exp busy=%b done=%b wrap=%b rem=%0d bin=%0d gray=%0d",
                         $time, busy, done, wrap, remaining, bin_out, gray_out,
                         e.busy, e.done, e.wrap, e.rem, e.bin, e.gray);
            end
        end
    end

    initial begin
        #2000000;
        miscompares++;
        $display("FAIL timeout: stimulus did not complete within the wait limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst = 1; start = 0; steps = '0; pause = 0; stop = 0; clr = 0; dir = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 1, 1, 0);
        @(posedge clk);
        #2;
        if (busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0 ||
            remaining !== '0 || bin_out !== '0 || gray_out !== '0) begin
            miscompares++;
            $display("FAIL reset state t=%0t busy=%b done=%b wrap=%b rem=%0d bin=%0d gray=%0d",
                     $time, busy, done, wrap, remaining, bin_out, gray_out);
        end
        idle(2);
        // run of 3 from zero: bin 1,2,3, done with bin 3
        cyc(0, 1, 3, 0, 0, 0, 0);
        idle(4);
        // start with zero steps is ignored
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        // reach 8, then 4 steps across the wrap: 9,0,1,2
        cyc(0, 1, 5, 0, 0, 0, 0);
        idle(6);
        cyc(0, 1, 4, 0, 0, 0, 0);
        idle(5);
        // pause for 3 cycles after the 2nd advance
        cyc(0, 1, 5, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 7, 1, 0, 1, 0);
        idle(7);
        // stop together with pause at remaining 4, then clr
        cyc(0, 1, 6, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 1, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(2);
        // reset mid-run at bin 7, start right after release
        cyc(0, 1, 10, 0, 0, 0, 0);
        idle(7);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0);
        idle(5);
`ifdef GRAY_SEQ_DOWN_EN
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        idle(3);
        cyc(0, 1, 3, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
`endif
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
                ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14),
                $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        end
        idle(1);
        @(negedge clk);
        if (exp_q.size() != 0 || vectors == 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never compared, %0d compared",
                     exp_q.size(), vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
